// File: rtl/sdm_decim_pkg.sv
// Shared sizing helpers and default-width types for the sinc3 sigma-delta decimator.
package sdm_decim_pkg;

    localparam int DEC_LOG2_DEF = 6;
    localparam int DOUT_W_DEF   = 16;

    // Three integrators of OSR gain plus sign and one guard bit for +OSR^3.
    function automatic int calc_acc_w(input int dec_log2);
        return 3 * dec_log2 + 2;
    endfunction

    localparam int ACC_W_DEF = calc_acc_w(DEC_LOG2_DEF);

    typedef logic signed [ACC_W_DEF-1:0] acc_t;

    localparam int DOUT_MAX = (1 << (DOUT_W_DEF - 1)) - 1;
    localparam int DOUT_MIN = -(1 << (DOUT_W_DEF - 1));

endpackage

// File: rtl/sdm_cic_comb.sv
// One CIC comb stage: out = in - in delayed by one decimated sample.
module sdm_cic_comb #(
    parameter int W = 20
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_upd,
    input  logic signed [W-1:0] i_din,
    output logic signed [W-1:0] o_dout
);

    logic signed [W-1:0] r_dly;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_dly <= '0;
        end else if (i_upd) begin
            r_dly <= i_din;
        end
    end

    assign o_dout = i_din - r_dly;

endmodule

// File: rtl/sdm_decim_cic.sv
// Third-order CIC decimator for a 1-bit sigma-delta stream with valid/ready PCM output.
// Build option: define SDM_DECIM_ROUND_EN for round-half-up scaling instead of floor.
module sdm_decim_cic
    import sdm_decim_pkg::*;
#(
    parameter int DEC_LOG2      = 6,
    parameter int DOUT_W        = 16,
    parameter int SETTLE_FRAMES = 2
) (
    input  logic                     clk_1mhz,
    input  logic                     reset_n,
    input  logic                     en,
    input  logic                     din,
    output logic signed [DOUT_W-1:0] dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic                     overrun,
    input  logic                     overrun_clr
);

    localparam int ACC_W = calc_acc_w(DEC_LOG2);
    localparam int SH    = 3 * DEC_LOG2 - (DOUT_W - 1);

    localparam logic [DEC_LOG2-1:0]     PH_LAST  = '1;
    localparam logic [7:0]              SETTLE_N = 8'(SETTLE_FRAMES);
    localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'((1 << (DOUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN  = ~SAT_MAX;
`ifdef SDM_DECIM_ROUND_EN
    localparam logic signed [ACC_W-1:0] RND = (SH > 0) ? ACC_W'(1 << ((SH > 0) ? SH - 1 : 0)) : '0;
`else
    localparam logic signed [ACC_W-1:0] RND = '0;
`endif

    logic signed [ACC_W-1:0]  r_i1, r_i2, r_i3;
    logic signed [ACC_W-1:0]  w_x;
    logic [DEC_LOG2-1:0]      r_phase;
    logic                     w_tick;
    logic                     r_tick_d;
    logic                     r_en_d;
    logic [7:0]               r_settle;
    logic                     w_settled;
    logic                     w_load;
    logic signed [ACC_W-1:0]  w_c1, w_c2, w_y;
    logic signed [ACC_W-1:0]  w_shift;
    logic signed [DOUT_W-1:0] w_sat;
    logic signed [DOUT_W-1:0] r_dout;
    logic                     r_valid;
    logic                     r_overrun;

    assign w_x    = din ? {{(ACC_W-1){1'b0}}, 1'b1} : {ACC_W{1'b1}};
    assign w_tick = en && (r_phase == PH_LAST);

    // Integrators wrap freely; the combs recover the exact result modulo 2^ACC_W.
    always_ff @(posedge clk_1mhz) begin
        if (!reset_n) begin
            r_i1    <= '0;
            r_i2    <= '0;
            r_i3    <= '0;
            r_phase <= '0;
        end else if (en) begin
            r_i1    <= r_i1 + w_x;
            r_i2    <= r_i2 + r_i1;
            r_i3    <= r_i3 + r_i2;
            r_phase <= r_phase + DEC_LOG2'(1);
        end
    end

    always_ff @(posedge clk_1mhz) begin
        if (!reset_n) begin
            r_tick_d <= 1'b0;
            r_en_d   <= 1'b0;
        end else begin
            r_tick_d <= w_tick;
            r_en_d   <= en;
        end
    end

    sdm_cic_comb #(.W(ACC_W)) u_comb1 (
        .i_clk   (clk_1mhz),
        .i_rst_n (reset_n),
        .i_upd   (r_tick_d),
        .i_din   (r_i3),
        .o_dout  (w_c1)
    );

    sdm_cic_comb #(.W(ACC_W)) u_comb2 (
        .i_clk   (clk_1mhz),
        .i_rst_n (reset_n),
        .i_upd   (r_tick_d),
        .i_din   (w_c1),
        .o_dout  (w_c2)
    );

    sdm_cic_comb #(.W(ACC_W)) u_comb3 (
        .i_clk   (clk_1mhz),
        .i_rst_n (reset_n),
        .i_upd   (r_tick_d),
        .i_din   (w_c2),
        .o_dout  (w_y)
    );

    // |y| <= 2^(3*DEC_LOG2), so the rounding offset cannot overflow ACC_W.
    assign w_shift = (w_y + RND) >>> SH;

    always_comb begin
        w_sat = w_shift[DOUT_W-1:0];
        if (w_shift > SAT_MAX) begin
            w_sat = SAT_MAX[DOUT_W-1:0];
        end else if (w_shift < SAT_MIN) begin
            w_sat = SAT_MIN[DOUT_W-1:0];
        end
    end

    assign w_settled = (r_settle >= SETTLE_N);
    assign w_load    = r_tick_d && w_settled;

    // A tick needs en high, so an en rise never lands on a comb-update edge.
    always_ff @(posedge clk_1mhz) begin
        if (!reset_n) begin
            r_settle <= '0;
        end else if (en && !r_en_d) begin
            r_settle <= '0;
        end else if (r_tick_d && !w_settled) begin
            r_settle <= r_settle + 8'd1;
        end
    end

    always_ff @(posedge clk_1mhz) begin
        if (!reset_n) begin
            r_dout  <= '0;
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_dout  <= w_sat;
            r_valid <= 1'b1;
        end else if (r_valid && dout_ready) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_1mhz) begin
        if (!reset_n) begin
            r_overrun <= 1'b0;
        end else if (overrun_clr) begin
            r_overrun <= 1'b0;
        end else if (w_load && r_valid && !dout_ready) begin
            r_overrun <= 1'b1;
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_valid;
    assign overrun    = r_overrun;

endmodule
